// File: rtl/pwm_ramp_controller.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_ramp_controller
//  Purpose  : Ramps the PWM duty-cycle register toward a programmed target in
//             bounded steps, spaced by a prescale interval and applied only on
//             PWM period boundaries so no period sees a glitched compare.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_controller #(
    parameter int DUTY_W     = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  snap,
    input  logic [DUTY_W-1:0]     target_duty,
    input  logic [DUTY_W-1:0]     step_size,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  period_start,
    output logic [DUTY_W-1:0]     duty_cycle,
    output logic                  ramping,
    output logic                  at_target
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam logic [DUTY_W:0] c_ONE = {{DUTY_W{1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DUTY_W-1:0]     r_duty;
    logic [DUTY_W-1:0]     w_duty_nxt;
    logic [PRESCALE_W-1:0] r_cnt;
    logic [PRESCALE_W-1:0] w_cnt_nxt;
    logic                  r_at_target;
    logic                  w_at_target_nxt;

    logic                  w_up;
    logic [DUTY_W:0]       w_dist;
    logic [DUTY_W:0]       w_step;
    logic [DUTY_W:0]       w_delta;
    logic [DUTY_W-1:0]     w_stepped;

    // Candidate next duty: one clamped step toward the live target. The
    // distance is computed one bit wider so the clamp can never wrap.
    always_comb begin
        w_up      = (target_duty > r_duty);
        w_dist    = w_up ? ({1'b0, target_duty} - {1'b0, r_duty})
                         : ({1'b0, r_duty} - {1'b0, target_duty});
        w_step    = (step_size == '0) ? c_ONE : {1'b0, step_size};
        w_delta   = (w_step < w_dist) ? w_step : w_dist;
        w_stepped = w_up ? (r_duty + w_delta[DUTY_W-1:0])
                         : (r_duty - w_delta[DUTY_W-1:0]);
    end

    // Next-state / next-output decode; snap outranks every ramp rule.
    always_comb begin
        w_state_nxt     = r_state;
        w_duty_nxt      = r_duty;
        w_cnt_nxt       = r_cnt;
        w_at_target_nxt = 1'b0;

        if (snap) begin
            w_state_nxt     = IDLE;
            w_duty_nxt      = target_duty;
            w_cnt_nxt       = '0;
            w_at_target_nxt = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable && (target_duty != r_duty)) begin
                        w_state_nxt = RAMP;
                        w_cnt_nxt   = prescale;
                    end
                end
                RAMP: begin
                    if (!enable) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (target_duty == r_duty) begin
                        w_state_nxt     = IDLE;
                        w_at_target_nxt = 1'b1;
                    end else if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else if (period_start) begin
                        w_duty_nxt = w_stepped;
                        w_cnt_nxt  = prescale;
                        if (w_stepped == target_duty) begin
                            w_state_nxt     = IDLE;
                            w_at_target_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_duty      <= '0;
            r_cnt       <= '0;
            r_at_target <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_duty      <= w_duty_nxt;
            r_cnt       <= w_cnt_nxt;
            r_at_target <= w_at_target_nxt;
        end
    end

    assign duty_cycle = r_duty;
    assign ramping    = (r_state == RAMP);
    assign at_target  = r_at_target;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_ramp_controller
//  Purpose  : Self-checking bench for pwm_ramp_controller: directed scenarios
//             plus randomized traffic against a timestamp-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        snap;
    logic [7:0]  target_duty;
    logic [7:0]  step_size;
    logic [15:0] prescale;
    logic        period_start;
    logic [7:0]  duty_cycle;
    logic        ramping;
    logic        at_target;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers and an absolute "earliest step"
    // edge number instead of a down-counter.
    int m_duty  = 0;
    bit m_ramp  = 0;
    bit m_at    = 0;
    int m_ready = 0;
    int edge_no = 0;

    pwm_ramp_controller #(
        .DUTY_W     (8),
        .PRESCALE_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .snap         (snap),
        .target_duty  (target_duty),
        .step_size    (step_size),
        .prescale     (prescale),
        .period_start (period_start),
        .duty_cycle   (duty_cycle),
        .ramping      (ramping),
        .at_target    (at_target)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_edge();
        int tgt;
        int s;
        int d;
        tgt  = int'(target_duty);
        m_at = 0;
        if (!rst_n) begin
            m_duty = 0;
            m_ramp = 0;
        end else if (snap) begin
            m_duty = tgt;
            m_ramp = 0;
            m_at   = 1;
        end else if (!m_ramp) begin
            if (enable && tgt != m_duty) begin
                m_ramp  = 1;
                m_ready = edge_no + int'(prescale) + 1;
            end
        end else if (!enable) begin
            m_ramp = 0;
        end else if (tgt == m_duty) begin
            m_ramp = 0;
            m_at   = 1;
        end else if (edge_no >= m_ready && period_start) begin
            s = (step_size == 0) ? 1 : int'(step_size);
            d = (tgt > m_duty) ? tgt - m_duty : m_duty - tgt;
            if (s > d) s = d;
            m_duty  = (tgt > m_duty) ? m_duty + s : m_duty - s;
            m_ready = edge_no + int'(prescale) + 1;
            if (m_duty == tgt) begin
                m_ramp = 0;
                m_at   = 1;
            end
        end
        edge_no++;
    endtask

    // One clock edge; outputs are stable and comparable on return.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; target_duty = 8'hFF; snap = 1'b0;
        step_size = 8'd1; prescale = 16'd0; period_start = 1'b0;
        tick();
        tick();
        checks++;
        if ({duty_cycle, ramping, at_target} !== {8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got duty=%0d ramp=%0b at=%0b want 0/0/0",
                     duty_cycle, ramping, at_target);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (ramping !== 1'b1 || duty_cycle !== 8'd0) begin
            errors++;
            $display("FAIL reset_release got ramp=%0b duty=%0d want ramp=1 duty=0",
                     ramping, duty_cycle);
        end
    endtask

    task automatic test_up_ramp();
        logic [7:0] seen[$];
        logic [7:0] exp_seq[3];
        logic [7:0] prev;
        int pulses;
        exp_seq = '{8'd4, 8'd8, 8'd10};
        target_duty = 8'd10; step_size = 8'd4; prescale = 16'd0;
        enable = 1'b1; snap = 1'b0; period_start = 1'b0;
        do_reset();
        prev = duty_cycle; pulses = 0;
        for (int i = 0; i < 64; i++) begin
            period_start = (i % 16 == 15);
            tick();
            checks++;
            if ({duty_cycle, ramping, at_target} !== {8'(m_duty), m_ramp, m_at}) begin
                errors++;
                $display("FAIL up_ramp cyc%0d got %0d/%0b/%0b want %0d/%0b/%0b", i,
                         duty_cycle, ramping, at_target, m_duty, m_ramp, m_at);
            end
            if (duty_cycle !== prev) seen.push_back(duty_cycle);
            if (at_target) pulses++;
            prev = duty_cycle;
        end
        period_start = 1'b0;
        checks++;
        if (seen.size() != 3 || seen[0] !== exp_seq[0] || seen[1] !== exp_seq[1]
            || seen[2] !== exp_seq[2] || pulses != 1) begin
            errors++;
            $display("FAIL up_ramp_seq got %0d changes, %0d pulses want 4,8,10 and 1 pulse",
                     seen.size(), pulses);
        end
    endtask

    task automatic test_prescale();
        int steps;
        logic [7:0] prev;
        target_duty = 8'd3; step_size = 8'd1; prescale = 16'd40;
        enable = 1'b1; snap = 1'b0; period_start = 1'b0;
        do_reset();
        prev = duty_cycle; steps = 0;
        for (int i = 0; i < 260; i++) begin
            period_start = (i % 16 == 15);
            tick();
            checks++;
            if ({duty_cycle, ramping, at_target} !== {8'(m_duty), m_ramp, m_at}) begin
                errors++;
                $display("FAIL prescale cyc%0d got %0d/%0b/%0b want %0d/%0b/%0b", i,
                         duty_cycle, ramping, at_target, m_duty, m_ramp, m_at);
            end
            if (duty_cycle !== prev) steps++;
            prev = duty_cycle;
        end
        period_start = 1'b0;
        checks++;
        if (steps != 3 || duty_cycle !== 8'd3) begin
            errors++;
            $display("FAIL prescale_steps got %0d steps duty=%0d want 3 steps duty=3",
                     steps, duty_cycle);
        end
    endtask

    task automatic test_reversal();
        enable = 1'b1; step_size = 8'd8; prescale = 16'd0; period_start = 1'b0;
        snap = 1'b0; target_duty = 8'd0;
        do_reset();
        snap = 1'b1; target_duty = 8'd100;
        tick();
        snap = 1'b0; target_duty = 8'd120;
        tick();
        target_duty = 8'd96;
        tick();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        checks++;
        if ({duty_cycle, ramping, at_target} !== {8'd96, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reversal got %0d/%0b/%0b want 96/0/1",
                     duty_cycle, ramping, at_target);
        end
        tick();
        checks++;
        if ({duty_cycle, ramping, at_target} !== {8'd96, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reversal_settle got %0d/%0b/%0b want 96/0/0",
                     duty_cycle, ramping, at_target);
        end
    endtask

    task automatic test_snap_disable();
        enable = 1'b1; prescale = 16'd0; period_start = 1'b0; snap = 1'b0;
        target_duty = 8'd0;
        do_reset();
        snap = 1'b1; target_duty = 8'd40;
        tick();
        snap = 1'b0; target_duty = 8'd60; step_size = 8'd10;
        tick();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        checks++;
        if (duty_cycle !== 8'd50 || ramping !== 1'b1) begin
            errors++;
            $display("FAIL snap_setup got duty=%0d ramp=%0b want 50/1", duty_cycle, ramping);
        end
        snap = 1'b1; target_duty = 8'd200;
        tick();
        snap = 1'b0;
        checks++;
        if ({duty_cycle, ramping, at_target} !== {8'd200, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL snap got %0d/%0b/%0b want 200/0/1", duty_cycle, ramping, at_target);
        end
        target_duty = 8'd0; enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            period_start = (i % 3 == 0);
            tick();
            checks++;
            if ({duty_cycle, ramping, at_target} !== {8'd200, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL disable cyc%0d got %0d/%0b/%0b want 200/0/0", i,
                         duty_cycle, ramping, at_target);
            end
        end
        period_start = 1'b0;
    endtask

    task automatic test_bounds();
        logic [7:0] prev;
        enable = 1'b1; prescale = 16'd0; period_start = 1'b0; snap = 1'b0;
        target_duty = 8'd0;
        do_reset();
        snap = 1'b1; target_duty = 8'd250;
        tick();
        snap = 1'b0; target_duty = 8'd255; step_size = 8'd0;
        prev = duty_cycle;
        for (int i = 0; i < 14; i++) begin
            period_start = i[0];
            tick();
            checks++;
            if (duty_cycle < prev || duty_cycle !== 8'(m_duty)) begin
                errors++;
                $display("FAIL bounds_up cyc%0d got %0d want %0d (prev %0d)", i,
                         duty_cycle, m_duty, prev);
            end
            prev = duty_cycle;
        end
        checks++;
        if (duty_cycle !== 8'd255) begin
            errors++;
            $display("FAIL bounds_top got %0d want 255", duty_cycle);
        end
        target_duty = 8'd0; step_size = 8'd255; period_start = 1'b0;
        tick();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        checks++;
        if ({duty_cycle, ramping, at_target} !== {8'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL bounds_down got %0d/%0b/%0b want 0/0/1",
                     duty_cycle, ramping, at_target);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            rst_n        = ($urandom_range(0, 299) != 0);
            snap         = ($urandom_range(0, 59) == 0);
            enable       = ($urandom_range(0, 19) != 0);
            period_start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 24) == 0) target_duty = 8'($urandom);
            if ($urandom_range(0, 39) == 0) step_size   = 8'($urandom_range(0, 40));
            if ($urandom_range(0, 39) == 0) prescale    = 16'($urandom_range(0, 20));
            tick();
            checks++;
            if ({duty_cycle, ramping, at_target} !== {8'(m_duty), m_ramp, m_at}) begin
                errors++;
                $display("FAIL random cyc%0d got %0d/%0b/%0b want %0d/%0b/%0b", i,
                         duty_cycle, ramping, at_target, m_duty, m_ramp, m_at);
            end
        end
        rst_n = 1'b1; snap = 1'b0; period_start = 1'b0;
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_up_ramp();
        test_prescale();
        test_reversal();
        test_snap_disable();
        test_bounds();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_ramp_controller.md
Name: pwm_ramp_controller

Overview:
- Sequences the 8-bit PWM duty-cycle register. It ramps the duty value handed to the PWM peripheral from its current value toward an SPI-programmed target.
- The ramp moves in programmable steps, spaced by a programmable prescale interval.
- Every duty update is applied only on a PWM period boundary, so no PWM period ever sees a glitched compare value.
- Sits between the SPI register file (target/config) and the PWM peripheral (duty input, period-start pulse).

Parameters:
- DUTY_W, 8, width of duty, target and step values
- PRESCALE_W, 16, width of the inter-step prescale counter

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- enable  input  1  ramp enable; 0 freezes duty_cycle at its current value
- snap  input  1  one-cycle request to jump duty_cycle directly to target_duty
- target_duty  input  DUTY_W  desired duty value (SPI register)
- step_size  input  DUTY_W  maximum duty change per step; 0 is treated as 1
- prescale  input  PRESCALE_W  minimum clk cycles between steps
- period_start  input  1  one-cycle pulse from the PWM peripheral when its counter wraps to 0
- duty_cycle  output  DUTY_W  duty value driven to the PWM peripheral (registered)
- ramping  output  1  high while in RAMP state
- at_target  output  1  one-cycle pulse when duty_cycle reaches target_duty

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is synchronous, active-low. While rst_n=0 at a clk edge:
  - duty_cycle=0, ramping=0, at_target=0
  - prescale counter cnt=0, state=IDLE
  - Reset mid-ramp abandons the ramp; there is no partial-step completion.
- State machine: two states, IDLE and RAMP; ramping = (state==RAMP).
- IDLE:
  - If enable=1 and target_duty != duty_cycle: go to RAMP and load cnt <= prescale.
  - Otherwise hold; duty_cycle is unchanged.
- RAMP, evaluated each cycle in this priority order:
  1. enable=0: go to IDLE; duty_cycle held; cnt cleared; no at_target pulse.
  2. target_duty == duty_cycle (target moved onto the current value): go to IDLE and pulse at_target.
  3. cnt != 0: cnt <= cnt-1.
  4. cnt == 0 and period_start=1: apply one step (below) and reload cnt <= prescale. If the new duty equals target_duty, pulse at_target and go to IDLE.
  5. cnt == 0 and period_start=0: wait; cnt stays 0.
- Step arithmetic:
  - s = (step_size==0) ? 1 : step_size; d = |target_duty - duty_cycle|, computed DUTY_W+1 wide.
  - Up ramp: duty_cycle <= duty_cycle + min(s,d). Down ramp: duty_cycle <= duty_cycle - min(s,d).
  - Never overshoots target, never wraps past 0 or 2^DUTY_W-1.
  - Direction and d use target_duty sampled in the step cycle, so a mid-ramp target change reverses or extends the ramp without restarting cnt.
- Latency:
  - duty_cycle changes only in the cycle after a clk edge at which a step is taken.
  - prescale=0: a step occurs on every period_start.
  - prescale=P: at least P cycles elapse after RAMP entry or after the previous step before the next step may occur; the step then waits for the next period_start.
- snap:
  - snap=1 at any clk edge (and rst_n=1) gives: duty_cycle <= target_duty, cnt <= 0, state <= IDLE.
  - at_target pulses in the same update.
  - snap overrides all RAMP rules and ignores enable and period_start.
- at_target is registered and is high for exactly one cycle per arrival event. It is not re-asserted while duty_cycle stays equal to target_duty in IDLE.
- prescale and step_size are sampled live: a change takes effect at the next reload or step respectively.
- period_start pulses arriving while in IDLE are ignored.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles while enable=1 and target_duty=8'hFF -> duty_cycle=0, ramping=0, at_target=0. Release -> RAMP entered on the next edge.
- Up ramp: duty=0, target=10, step=4, prescale=0, period_start every 16 cycles -> duty sequence 4, 8, 10, each change one cycle after a period_start. at_target pulses once with the 10 update; ramping falls together with it.
- Prescale gating: duty=0, target=3, step=1, prescale=40, period_start every 16 cycles -> each step lands on the first period_start at least 40 cycles after the previous reload (every third pulse). Exactly 3 steps occur.
- Mid-ramp reversal: ramping up with duty=100, step=8; set target=96 before the next step -> next step gives duty=96 (clamped), then at_target pulses and the block returns to IDLE with no overshoot.
- Snap and disable: mid-ramp at duty=50, pulse snap with target=200 -> duty=200 next cycle, at_target=1 for one cycle, IDLE. Then target=0 with enable=0 -> duty stays 200, ramping=0.
- Bounds: duty=250, target=255, step=0 -> steps of 1 to 255, no wrap. Then target=0, step=255 -> a single step to 0.
